mem_burst_master: RTL and testbench

- Upstream request engine for the single-port synchronous memory.
- Accepts one burst command (base address, beat count, direction) and breaks it into single-beat valid/ready requests on the memory port.
- On writes, write data comes from an input valid/ready stream. On reads, returned data goes to an output valid/ready stream with backpressure.
- Sits between the system command/data fabric and the memory instance.

---
 rtl/mem_burst_master_pkg.sv | 27 ++
 rtl/mem_burst_master_if.sv | 35 +++
 rtl/mem_rdata_buf.sv | 36 +++
 rtl/mem_burst_master.sv | 167 ++++++++++++++++
 tb/tb_mem_burst_master.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_burst_master_pkg.sv
// Shared types and constants for the burst master.
// Widths and depth must track the memory instance.
package mem_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  localparam logic DIR_WRITE = 1'b1;
  localparam logic DIR_READ  = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  // Address step that wraps at the last location,
  // so non-power-of-two depths still wrap correctly.
  function automatic int unsigned wrap_inc(
    input int unsigned a,
    input int unsigned depth
  );
    return (a == depth - 1) ? 0 : a + 1;
  endfunction

endpackage

// File: rtl/mem_burst_master_if.sv
// Single-beat request/response port to the memory.
// The master drives requests; the slave answers.
interface mem_burst_master_if
  import mem_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_WIDTH = $clog2(DEF_DEPTH)
) ();

  logic                  mem_valid_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_write_read_o;
  logic [WIDTH-1:0]      mem_write_data_o;
  logic                  mem_ready_i;
  logic [WIDTH-1:0]      mem_read_data_i;

  modport master (
    output mem_valid_o,
    output mem_addr_o,
    output mem_write_read_o,
    output mem_write_data_o,
    input  mem_ready_i,
    input  mem_read_data_i
  );

  modport slave (
    input  mem_valid_o,
    input  mem_addr_o,
    input  mem_write_read_o,
    input  mem_write_data_o,
    output mem_ready_i,
    output mem_read_data_i
  );

endinterface

// File: rtl/mem_rdata_buf.sv
// One-entry output register for the read stream.
// A new load always wins over a same-cycle drain.
module mem_rdata_buf
  import mem_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Hold one beat until the consumer takes it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/mem_burst_master.sv
// Splits a burst command into single-beat memory
// requests, fed by a write stream or to a read stream.
module mem_burst_master
  import mem_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic                  write_read_i,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  wdata_valid_i,
  output logic                  wdata_ready_o,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  rdata_valid_o,
  input  logic                  rdata_ready_i,
  mem_burst_master_if.master    m_bus
);

  state_t r_state;
  state_t w_next;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic                  r_dir;
  logic                  r_busy;
  logic                  r_done;

  logic                  r_mvalid;
  logic [ADDR_WIDTH-1:0] r_maddr;
  logic                  r_mwr;
  logic [WIDTH-1:0]      r_mwdata;

  logic w_accept;
  logic w_issue_wr;
  logic w_issue_rd;
  logic w_beat;
  logic w_rd_load;
  logic w_rvalid;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next state and per-cycle control strobes
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_issue_wr = 1'b0;
    w_issue_rd = 1'b0;
    w_beat     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_accept = 1'b1;
          w_next   = (len_i == '0) ? ST_DONE
                                   : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (r_dir == DIR_WRITE) begin
          if (wdata_valid_i) begin
            w_issue_wr = 1'b1;
            w_next     = ST_WAIT;
          end
        end else if (!w_rvalid ||
                     rdata_ready_i) begin
          w_issue_rd = 1'b1;
          w_next     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (m_bus.mem_ready_i) begin
          w_beat = 1'b1;
          w_next = (r_cnt == LEN_WIDTH'(1))
                   ? ST_DONE : ST_ISSUE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Burst address, remaining beats and direction
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr <= '0;
      r_cnt  <= '0;
      r_dir  <= DIR_READ;
    end else if (w_accept) begin
      r_addr <= base_addr_i;
      r_cnt  <= len_i;
      r_dir  <= write_read_i;
    end else if (w_beat) begin
      r_addr <= ADDR_WIDTH'(
        wrap_inc(32'(r_addr), DEPTH));
      r_cnt  <= r_cnt - LEN_WIDTH'(1);
    end
  end

  // Registered memory request, one cycle per beat
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mvalid <= 1'b0;
      r_maddr  <= '0;
      r_mwr    <= 1'b0;
      r_mwdata <= '0;
    end else begin
      r_mvalid <= w_issue_wr || w_issue_rd;
      if (w_issue_wr || w_issue_rd) begin
        r_maddr <= r_addr;
        r_mwr   <= r_dir;
      end
      if (w_issue_wr) r_mwdata <= wdata_i;
    end
  end

  // Busy spans acceptance to completion; done pulses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == ST_DONE);
      if (w_accept)
        r_busy <= 1'b1;
      else if (r_state == ST_DONE)
        r_busy <= 1'b0;
    end
  end

  assign w_rd_load = w_beat && (r_dir == DIR_READ);

  mem_rdata_buf #(
    .WIDTH (WIDTH)
  ) u_rbuf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_load  (w_rd_load),
    .i_data  (m_bus.mem_read_data_i),
    .i_ready (rdata_ready_i),
    .o_data  (rdata_o),
    .o_valid (w_rvalid)
  );

  assign rdata_valid_o = w_rvalid;
  assign wdata_ready_o = (r_state == ST_ISSUE) &&
                         (r_dir == DIR_WRITE);
  assign busy_o = r_busy;
  assign done_o = r_done;

  assign m_bus.mem_valid_o      = r_mvalid;
  assign m_bus.mem_addr_o       = r_maddr;
  assign m_bus.mem_write_read_o = r_mwr;
  assign m_bus.mem_write_data_o = r_mwdata;

endmodule

// File: tb/tb_mem_burst_master.sv
// Scoreboard bench for the burst master with a
// one-cycle-latency memory model behind it.
module tb_mem_burst_master;

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
    logic       w;
  } req_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] base = '0;
  logic [4:0] len = '0;
  logic       wr = 1'b0;
  logic [7:0] wdata = '0;
  logic       wvalid = 1'b0;
  logic       rready = 1'b1;
  logic       wready;
  logic [7:0] rdata;
  logic       rvalid;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;
  int n_req    = 0;
  int n_rd     = 0;
  int n_done   = 0;

  req_t       exp_req[$];
  logic [7:0] exp_rd[$];
  logic [7:0] wq[$];
  logic [7:0] mem[16];

  mem_burst_master_if #(
    .WIDTH(8), .ADDR_WIDTH(4)) bus ();

  mem_burst_master #(
    .WIDTH(8), .DEPTH(16)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .base_addr_i   (base),
    .len_i         (len),
    .write_read_i  (wr),
    .busy_o        (busy),
    .done_o        (done),
    .wdata_i       (wdata),
    .wdata_valid_i (wvalid),
    .wdata_ready_o (wready),
    .rdata_o       (rdata),
    .rdata_valid_o (rvalid),
    .rdata_ready_i (rready),
    .m_bus         (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      bus.mem_ready_i <= 1'b0;
    end else begin
      bus.mem_ready_i <= bus.mem_valid_o;
    end
    if (bus.mem_valid_o) begin
      if (bus.mem_write_read_o)
        mem[bus.mem_addr_o] <= bus.mem_write_data_o;
      else
        bus.mem_read_data_i <= mem[bus.mem_addr_o];
    end
  end

  always @(negedge clk) begin
    req_t e;
    logic [7:0] d;
    if (!rst) begin
      if (done) n_done++;
      if (bus.mem_valid_o) begin
        n_req++;
        n_checks++;
        if (exp_req.size() == 0) begin
          n_fail++;
          $display("FAIL req_extra got a=%0d w=%0b",
            bus.mem_addr_o, bus.mem_write_read_o);
        end else begin
          e = exp_req.pop_front();
          if (bus.mem_addr_o !== e.a ||
              bus.mem_write_read_o !== e.w ||
              (e.w && bus.mem_write_data_o !== e.d)) begin
            n_fail++;
            $display(
              "FAIL req got a=%0d w=%0b d=%h want a=%0d w=%0b d=%h",
              bus.mem_addr_o, bus.mem_write_read_o,
              bus.mem_write_data_o, e.a, e.w, e.d);
          end
        end
      end
      if (rvalid && rready) begin
        n_rd++;
        n_checks++;
        if (exp_rd.size() == 0) begin
          n_fail++;
          $display("FAIL rdata_extra got %h", rdata);
        end else begin
          d = exp_rd.pop_front();
          if (rdata !== d) begin
            n_fail++;
            $display("FAIL rdata got %h want %h",
              rdata, d);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_burst(
    input  logic       i_wr,
    input  logic [3:0] i_base,
    input  logic [4:0] i_len,
    input  int         stall_at,
    input  int         stall_len,
    input  int         bp_len,
    output int         cyc_done,
    output logic       busy1,
    output int         req_bp,
    output bit         stall_ok
  );
    int  sent;
    int  left_s;
    int  left_b;
    int  req0;
    bit  xfer;
    sent = 0;
    left_s = stall_len;
    left_b = bp_len;
    cyc_done = -1;
    busy1 = 1'b0;
    req0 = n_req;
    req_bp = -1;
    stall_ok = 1'b1;
    step();
    start = 1'b1;
    base = i_base;
    len = i_len;
    wr = i_wr;
    rready = (bp_len == 0);
    wvalid = i_wr && (wq.size() > 0);
    wdata = (wq.size() > 0) ? wq[0] : 8'h00;
    xfer = wvalid && wready;
    for (int c = 1; c < 300 && cyc_done < 0; c++) begin
      step();
      start = 1'b0;
      if (xfer) begin
        void'(wq.pop_front());
        sent++;
      end
      if (c == 1) busy1 = busy;
      if (done) cyc_done = c;
      if (i_wr && sent == stall_at && left_s > 0) begin
        if (left_s < stall_len && !wready)
          stall_ok = 1'b0;
        if (wready && bus.mem_valid_o)
          stall_ok = 1'b0;
        wvalid = 1'b0;
        if (wready) left_s--;
      end else begin
        wvalid = i_wr && (wq.size() > 0);
      end
      wdata = (wq.size() > 0) ? wq[0] : 8'h00;
      if (!i_wr && left_b > 0) begin
        rready = 1'b0;
        if (rvalid) begin
          left_b--;
          if (left_b == 0) req_bp = n_req - req0;
        end
      end else begin
        rready = 1'b1;
      end
      xfer = wvalid && wready;
    end
    start = 1'b0;
    wvalid = 1'b0;
    rready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_checks++;
    if ({busy, done, wready, rvalid,
         bus.mem_valid_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctl got %b want 00000",
        {busy, done, wready, rvalid,
         bus.mem_valid_o});
    end
    n_checks++;
    if ({rdata, bus.mem_addr_o,
         bus.mem_write_data_o,
         bus.mem_write_read_o} !== 21'b0) begin
      n_fail++;
      $display("FAIL reset_data got %h want 0",
        {rdata, bus.mem_addr_o,
         bus.mem_write_data_o,
         bus.mem_write_read_o});
    end
    rst = 1'b0;
    step();
    n_checks++;
    if ({busy, done, bus.mem_valid_o} !== 3'b0) begin
      n_fail++;
      $display("FAIL reset_idle got %b want 000",
        {busy, done, bus.mem_valid_o});
    end
  endtask

  task automatic test_write_basic();
    int cd, rb, d0, q0;
    logic b1;
    bit so;
    d0 = n_done;
    q0 = n_req;
    for (int i = 0; i < 3; i++) begin
      wq.push_back(8'hA1 + 8'(i));
      exp_req.push_back('{4'(4 + i),
                          8'hA1 + 8'(i), 1'b1});
    end
    run_burst(1'b1, 4'd4, 5'd3, -1, 0, 0,
              cd, b1, rb, so);
    n_checks++;
    if (cd < 0) begin
      n_fail++;
      $display("FAIL wr_done timeout");
    end
    n_checks++;
    if (b1 !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_busy got %b want 1", b1);
    end
    step();
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL wr_after got %b want 00",
        {busy, done});
    end
    step();
    n_checks++;
    if (n_done - d0 != 1 || n_req - q0 != 3 ||
        exp_req.size() != 0) begin
      n_fail++;
      $display("FAIL wr_count done=%0d req=%0d left=%0d want 1 3 0",
        n_done - d0, n_req - q0, exp_req.size());
    end
  endtask

  task automatic test_read_basic();
    int cd, rb, d0, r0;
    logic b1;
    bit so;
    d0 = n_done;
    r0 = n_rd;
    for (int i = 0; i < 3; i++) begin
      exp_req.push_back('{4'(4 + i), 8'h00, 1'b0});
      exp_rd.push_back(8'hA1 + 8'(i));
    end
    run_burst(1'b0, 4'd4, 5'd3, -1, 0, 0,
              cd, b1, rb, so);
    n_checks++;
    if (cd < 0) begin
      n_fail++;
      $display("FAIL rd_done timeout");
    end
    repeat (2) step();
    n_checks++;
    if (n_done - d0 != 1 || n_rd - r0 != 3 ||
        exp_rd.size() != 0 || exp_req.size() != 0) begin
      n_fail++;
      $display("FAIL rd_count done=%0d rd=%0d left=%0d want 1 3 0",
        n_done - d0, n_rd - r0, exp_rd.size());
    end
  endtask

  task automatic test_wrap();
    int cd, rb;
    logic b1;
    bit so;
    logic [3:0] a;
    a = 4'd14;
    for (int i = 0; i < 4; i++) begin
      wq.push_back(8'hB1 + 8'(i));
      exp_req.push_back('{a, 8'hB1 + 8'(i), 1'b1});
      a = a + 4'd1;
    end
    run_burst(1'b1, 4'd14, 5'd4, -1, 0, 0,
              cd, b1, rb, so);
    step();
    n_checks++;
    if (cd < 0 || exp_req.size() != 0) begin
      n_fail++;
      $display("FAIL wrap done=%0d left=%0d want >0 0",
        cd, exp_req.size());
    end
  endtask

  task automatic test_backpressure();
    int cd, rb, r0;
    logic b1;
    bit so;
    r0 = n_rd;
    for (int i = 0; i < 2; i++) begin
      exp_req.push_back('{4'(4 + i), 8'h00, 1'b0});
      exp_rd.push_back(8'hA1 + 8'(i));
    end
    run_burst(1'b0, 4'd4, 5'd2, -1, 0, 5,
              cd, b1, rb, so);
    n_checks++;
    if (rb != 1) begin
      n_fail++;
      $display("FAIL bp_reqs got %0d want 1", rb);
    end
    repeat (2) step();
    n_checks++;
    if (cd < 0 || n_rd - r0 != 2 ||
        exp_rd.size() != 0) begin
      n_fail++;
      $display("FAIL bp_data done=%0d rd=%0d want >0 2",
        cd, n_rd - r0);
    end
  endtask

  task automatic test_write_stall();
    int cd, rb;
    logic b1;
    bit so;
    for (int i = 0; i < 3; i++) begin
      wq.push_back(8'hC1 + 8'(i));
      exp_req.push_back('{4'(8 + i),
                          8'hC1 + 8'(i), 1'b1});
    end
    run_burst(1'b1, 4'd8, 5'd3, 1, 3, 0,
              cd, b1, rb, so);
    n_checks++;
    if (so !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_hold got %b want 1", so);
    end
    step();
    n_checks++;
    if (cd < 0 || exp_req.size() != 0) begin
      n_fail++;
      $display("FAIL stall_done done=%0d left=%0d",
        cd, exp_req.size());
    end
  endtask

  task automatic test_len_zero();
    int cd, rb, q0;
    logic b1;
    bit so;
    q0 = n_req;
    run_burst(1'b1, 4'd3, 5'd0, -1, 0, 0,
              cd, b1, rb, so);
    step();
    n_checks++;
    if (cd != 2 || n_req != q0) begin
      n_fail++;
      $display("FAIL len0 got cyc=%0d req=%0d want 2 0",
        cd, n_req - q0);
    end
  endtask

  task automatic test_reset_wait();
    int cd, rb, d0;
    logic b1;
    bit so;
    d0 = n_done;
    step();
    start = 1'b1;
    base = 4'd2;
    len = 5'd3;
    wr = 1'b1;
    wvalid = 1'b1;
    wdata = 8'hD1;
    exp_req.push_back('{4'd2, 8'hD1, 1'b1});
    step();
    start = 1'b0;
    step();
    wvalid = 1'b0;
    step();
    rst = 1'b1;
    step();
    n_checks++;
    if ({busy, done, wready, rvalid,
         bus.mem_valid_o, bus.mem_addr_o,
         bus.mem_write_data_o} !== 17'b0) begin
      n_fail++;
      $display("FAIL rst_wait got %h want 0",
        {busy, done, wready, rvalid,
         bus.mem_valid_o, bus.mem_addr_o,
         bus.mem_write_data_o});
    end
    rst = 1'b0;
    repeat (3) step();
    n_checks++;
    if (n_done != d0 || busy !== 1'b0 ||
        exp_req.size() != 0) begin
      n_fail++;
      $display("FAIL rst_abort done=%0d busy=%b want 0 0",
        n_done - d0, busy);
    end
    exp_req.push_back('{4'd4, 8'h00, 1'b0});
    exp_rd.push_back(8'hA1);
    run_burst(1'b0, 4'd4, 5'd1, -1, 0, 0,
              cd, b1, rb, so);
    repeat (2) step();
    n_checks++;
    if (cd < 0 || exp_rd.size() != 0 ||
        n_done != d0 + 1) begin
      n_fail++;
      $display("FAIL rst_rerun done=%0d left=%0d",
        cd, exp_rd.size());
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_basic();
    test_wrap();
    test_backpressure();
    test_write_stall();
    test_len_zero();
    test_reset_wait();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_checks, n_fail);
    $finish;
  end

endmodule
